// File: rtl/econet_rx.sv
// econet_rx: Econet HDLC receiver core with zero-bit destuffing, LSB-first byte assembly and CRC-16
module econet_rx #(
  parameter logic [15:0] FCS_INIT = 16'hFFFF,
  parameter logic [15:0] FCS_POLY = 16'h8408
) (
  input  logic        econet_clk,
  input  logic        valid_rst,
  input  logic        rx,
  input  logic        inhibit,
  output logic [7:0]  rx_byte,
  output logic [15:0] rx_fcs,
  output logic        rx_byte_ready,
  output logic        rx_frame_start,
  output logic        rx_frame_end,
  output logic        receiving
);
  typedef enum logic [1:0] {HUNT, FLAG, FRAME} state_t;
  state_t state, state_n;
  logic [2:0] ones, ones_n, dcnt, dcnt_n, bcnt, bcnt_n;
  logic [5:0] dl, dl_n;
  logic [7:0] sr, sr_n, byte_n;
  logic [15:0] fcs_n, crc_in;
  logic flag, abort, flush, push, adv, b, fb, ready_n, start_n, end_n, recv_n;
  always_comb begin
    flag = !rx && ones == 3'd6;
    abort = rx && ones == 3'd6;
    flush = inhibit || flag || abort;
    push = ones < 3'd5 || (!rx && ones == 3'd7);
    ones_n = inhibit || !rx ? 3'd0 : ones == 3'd7 ? ones : ones + 3'd1;
    dl_n = flush ? 6'd0 : push ? {rx, dl[5:1]} : dl;
    dcnt_n = flush ? 3'd0 : push && dcnt != 3'd6 ? dcnt + 3'd1 : dcnt;
    b = dl[0];
    adv = !inhibit && push && dcnt == 3'd6 && state != HUNT;
    crc_in = state == FLAG ? FCS_INIT : rx_fcs;
    fb = crc_in[0] ^ b;
    start_n = adv && state == FLAG;
    ready_n = adv && state == FRAME && bcnt == 3'd7;
    end_n = !inhibit && flag && state == FRAME;
    fcs_n = adv ? (crc_in >> 1) ^ (fb ? FCS_POLY : 16'h0) : rx_fcs;
    sr_n = adv ? {b, sr[7:1]} : sr;
    bcnt_n = adv ? (state == FLAG ? 3'd1 : bcnt + 3'd1) : bcnt;
    byte_n = ready_n ? sr_n : rx_byte;
    state_n = inhibit || abort ? HUNT : flag ? FLAG : adv ? FRAME : state;
    recv_n = state_n == FRAME || end_n;
  end
  // receiving stays up through the rx_frame_end cycle and drops one cycle later
  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      state <= HUNT;
      ones <= 3'd0;
      dcnt <= 3'd0;
      dl <= 6'd0;
      bcnt <= 3'd0;
      sr <= 8'd0;
      rx_byte <= 8'd0;
      rx_fcs <= 16'hFFFF;
      rx_byte_ready <= 1'b0;
      rx_frame_start <= 1'b0;
      rx_frame_end <= 1'b0;
      receiving <= 1'b0;
    end else begin
      state <= state_n;
      ones <= ones_n;
      dcnt <= dcnt_n;
      dl <= dl_n;
      bcnt <= bcnt_n;
      sr <= sr_n;
      rx_byte <= byte_n;
      rx_fcs <= fcs_n;
      rx_byte_ready <= ready_n;
      rx_frame_start <= start_n;
      rx_frame_end <= end_n;
      receiving <= recv_n;
    end
  end
endmodule

// File: tb/tb_econet_rx.sv
// tb_econet_rx: table-driven frames, corner-case sequences and randomized traffic checked per cycle against a queue-based model
module tb_econet_rx;
  logic econet_clk = 1'b0;
  logic valid_rst = 1'b1;
  logic rx = 1'b1;
  logic inhibit = 1'b0;
  logic [7:0] rx_byte;
  logic [15:0] rx_fcs;
  logic rx_byte_ready, rx_frame_start, rx_frame_end, receiving;

  econet_rx dut (
    .econet_clk(econet_clk), .valid_rst(valid_rst), .rx(rx), .inhibit(inhibit),
    .rx_byte(rx_byte), .rx_fcs(rx_fcs), .rx_byte_ready(rx_byte_ready),
    .rx_frame_start(rx_frame_start), .rx_frame_end(rx_frame_end), .receiving(receiving)
  );

  always #5 econet_clk = ~econet_clk;

  typedef struct { logic [31:0] data; int n; int flip; bit good; } vec_t;
  vec_t tbl[5];

  int vecs = 0, errs = 0;
  int starts, ends, tx_ones;
  logic [15:0] end_fcs;
  logic [7:0] got[$], exp_q[$], fd[$];
  bit rnd_inh = 0;

  int m_ones, nbits;
  bit dq[$];
  bit m_sync, m_frame;
  logic [7:0] fbits, e_byte;
  logic [15:0] e_fcs;
  logic e_ready, e_start, e_end, e_recv;

  function automatic logic [15:0] crc_bit(logic [15:0] c, logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 16'h8408 : 16'h0);
  endfunction

  function automatic logic ri();
    return rnd_inh && $urandom_range(0, 299) == 0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ones = 0; dq.delete(); m_sync = 0; m_frame = 0; nbits = 0; fbits = 8'h0;
    e_byte = 8'h0; e_fcs = 16'hFFFF; e_ready = 0; e_start = 0; e_end = 0; e_recv = 0;
  endtask

  // line rules: 5 ones then 0 = stuffed, 6 ones then 0 = flag, 7th one = abort;
  // a destuffed bit reaches the frame only once 6 newer bits have arrived
  task automatic model(logic r, logic inh);
    bit b;
    e_ready = 0; e_start = 0; e_end = 0;
    if (inh) begin
      m_ones = 0; dq.delete(); m_sync = 0; m_frame = 0;
    end else begin
      if (r) begin
        if (m_ones == 6) begin dq.delete(); m_sync = 0; m_frame = 0; end
        else if (m_ones < 5) dq.push_back(1'b1);
        if (m_ones < 7) m_ones++;
      end else begin
        if (m_ones == 6) begin
          dq.delete(); e_end = m_frame; m_frame = 0; m_sync = 1;
        end else if (m_ones != 5) dq.push_back(1'b0);
        m_ones = 0;
      end
      if (dq.size() > 6) begin
        b = dq.pop_front();
        if (m_sync) begin
          if (!m_frame) begin m_frame = 1; e_start = 1; e_fcs = 16'hFFFF; nbits = 0; end
          e_fcs = crc_bit(e_fcs, b);
          fbits[nbits % 8] = b;
          nbits++;
          if (nbits % 8 == 0) begin e_ready = 1; e_byte = fbits; end
        end
      end
    end
    e_recv = m_frame || e_end;
  endtask

  task automatic cmp();
    chk("cycle", int'({rx_byte, rx_fcs, rx_byte_ready, rx_frame_start, rx_frame_end, receiving}),
        int'({e_byte, e_fcs, e_ready, e_start, e_end, e_recv}));
    if (rx_byte_ready) got.push_back(rx_byte);
    starts += int'(rx_frame_start);
    ends += int'(rx_frame_end);
    if (rx_frame_end) end_fcs = rx_fcs;
  endtask

  task automatic step(logic r, logic inh);
    @(negedge econet_clk);
    rx = r; inhibit = inh;
    model(r, inh);
    @(posedge econet_clk);
    #1 cmp();
  endtask

  task automatic pulse_reset();
    @(negedge econet_clk);
    valid_rst = 1'b1; rx = 1'b1; inhibit = 1'b1;
    #1 model_reset();
    chk("reset state", int'({rx_byte, rx_fcs, rx_byte_ready, rx_frame_start, rx_frame_end, receiving}),
        int'({8'h00, 16'hFFFF, 4'b0000}));
    #1 valid_rst = 1'b0;
    model(1'b1, 1'b1);
    @(posedge econet_clk);
    #1 cmp();
  endtask

  task automatic send_bit(logic b);
    step(b, ri());
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin step(1'b0, ri()); tx_ones = 0; end
    end else tx_ones = 0;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int j = 0; j < 8; j++) step(f[j], ri());
    tx_ones = 0;
  endtask

  task automatic send_frame(int flip, bit with_fcs);
    logic [15:0] c;
    logic [7:0] bytes[$];
    int k;
    c = 16'hFFFF; k = 0;
    bytes = fd;
    foreach (fd[i]) for (int j = 0; j < 8; j++) c = crc_bit(c, fd[i][j]);
    c = ~c;
    if (with_fcs) begin bytes.push_back(c[7:0]); bytes.push_back(c[15:8]); end
    foreach (bytes[i]) exp_q.push_back(bytes[i]);
    foreach (bytes[i]) for (int j = 0; j < 8; j++) begin
      send_bit(bytes[i][j] ^ (k == flip));
      k++;
    end
  endtask

  task automatic good_frame();
    send_flag();
    fd = '{8'hC3, 8'h5A, 8'h00};
    send_frame(-1, 1);
    send_flag();
  endtask

  task automatic clr();
    starts = 0; ends = 0; end_fcs = 16'h0;
    got.delete(); exp_q.delete();
  endtask

  task automatic frame_chk(string nm, int s, int e, bit good, bit bytes_on);
    chk({nm, " starts"}, starts, s);
    chk({nm, " ends"}, ends, e);
    chk({nm, " fcs_ok"}, int'(end_fcs == 16'hF0B8), int'(good));
    if (bytes_on) begin
      chk({nm, " nbytes"}, got.size(), exp_q.size());
      foreach (exp_q[i])
        chk($sformatf("%s byte%0d", nm, i), i < got.size() ? int'(got[i]) : -1, int'(exp_q[i]));
    end
  endtask

  initial begin
    tbl[0] = '{32'h00FE0001, 4, -1, 1'b1};
    tbl[1] = '{32'h00FE0001, 4, 9, 1'b0};
    tbl[2] = '{32'h00007EFF, 2, -1, 1'b1};
    tbl[3] = '{32'h00813CA5, 3, -1, 1'b1};
    tbl[4] = '{32'h00000000, 0, -1, 1'b1};
    model_reset();
    clr();
    pulse_reset();
    repeat (10) step(1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      fd.delete();
      for (int j = 0; j < tbl[i].n; j++) fd.push_back(tbl[i].data[8*j +: 8]);
      clr();
      send_flag();
      send_frame(tbl[i].flip, 1'b1);
      send_flag();
      frame_chk($sformatf("vec%0d", i), 1, 1, tbl[i].good, tbl[i].flip < 0);
    end

    clr();
    send_flag();
    fd = '{8'h11, 8'h22};
    send_frame(-1, 1'b0);
    repeat (7) step(1'b1, 1'b0);
    chk("abort ends", ends, 0);
    chk("abort receiving", int'(receiving), 0);
    clr();
    good_frame();
    frame_chk("after abort", 1, 1, 1'b1, 1'b1);

    clr();
    repeat (4) send_flag();
    chk("idle starts", starts, 0);
    chk("idle ends", ends, 0);
    clr();
    send_flag();
    fd = '{8'h01, 8'h02};
    send_frame(-1, 1'b1);
    send_flag();
    fd = '{8'hFF};
    send_frame(-1, 1'b1);
    repeat (3) send_flag();
    frame_chk("shared flag", 2, 2, 1'b1, 1'b1);

    clr();
    send_flag();
    fd = '{8'hAA, 8'h55};
    send_frame(-1, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    chk("inhibit ends", ends, 0);
    chk("inhibit receiving", int'(receiving), 0);
    clr();
    good_frame();
    frame_chk("after inhibit", 1, 1, 1'b1, 1'b1);

    clr();
    send_flag();
    fd = '{8'h12, 8'h34};
    send_frame(-1, 1'b0);
    pulse_reset();
    chk("reset ends", ends, 0);
    clr();
    repeat (3) step(1'b1, 1'b0);
    good_frame();
    frame_chk("after reset", 1, 1, 1'b1, 1'b1);

    clr();
    rnd_inh = 1;
    repeat (150) begin
      case ($urandom_range(0, 3))
        1: send_flag();
        2: begin repeat (10) step(1'b1, ri()); send_flag(); end
        3: begin repeat ($urandom_range(0, 20)) step(1'($urandom_range(0, 1)), ri()); send_flag(); end
        default: ;
      endcase
      fd.delete();
      repeat ($urandom_range(0, 6)) fd.push_back(8'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(-1, 1'b0);
        repeat (7) step(1'b1, ri());
      end else begin
        send_frame($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 40)) : -1, 1'b1);
        send_flag();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
